nios2_mem_stream_loader: RTL and testbench
==========================================

Name: nios2_mem_stream_loader

Overview:
- Upstream feeder for the on-chip program/data RAM (32-bit words, byte enables, 16-bit word address, 51200 words, no waitrequest).
- Accepts an 8-bit byte stream (boot/UART loader path) and packs bytes little-endian into 32-bit words.
- Issues single-cycle writes to sequential word addresses from a programmed base, reports completion and a 16-bit byte checksum.

Parameters:
- DEPTH, 51200, number of 32-bit words in the target RAM; bounds check limit.
- ADDR_W, 16, word address width.
- CNT_W, 18, byte count width (covers DEPTH*4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr/byte_count; ignored unless IDLE
- base_addr  in  ADDR_W  first word address
- byte_count  in  CNT_W  bytes to load
- s_data  in  8  stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  byte accepted when s_valid & s_ready
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  lane enables, bit k = bits [8k+7:8k]
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  RAM clock enable, tied 1 out of reset
- busy  out  1  high in FILL/WRITE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle bounds-violation pulse
- checksum  out  16  sum mod 2^16 of accepted bytes, held after done

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except mem_clken=0 during reset, 1 after; pack buffer, lane, remaining, checksum cleared; partial word discarded; no write issued.
- States IDLE, FILL, WRITE, DONE; all outputs decoded from registered state/datapath (no combinational path from s_valid to mem_*).
- IDLE: start with byte_count==0 -> DONE next cycle, no writes. start with base_addr + ceil(byte_count/4) > DEPTH -> error=1 next cycle, stay IDLE, no writes, checksum unchanged. Else -> FILL; addr=base_addr, remaining=byte_count, lane=0, byteenable=0, data=0, checksum=0.
- FILL: s_ready=1. On handshake: byte into lane, set byteenable[lane], checksum+=byte, remaining-=1; if lane==3 or remaining was 1 -> WRITE, else lane+=1.
- WRITE (exactly 1 cycle): mem_chipselect=mem_write=1, s_ready=0, mem_address=addr, mem_writedata/mem_byteenable=packed buffer; unfilled lanes carry data 0 and enable 0. Next: remaining==0 -> DONE; else FILL with addr+=1, lane=0, buffer and enables cleared.
- DONE: done=1 for one cycle -> IDLE. busy=0 in DONE.
- mem_address/mem_writedata/mem_byteenable hold last values outside WRITE; only mem_write/mem_chipselect qualify them.
- Throughput: 4 bytes per 5 cycles when s_valid continuously high; s_valid gaps stall FILL indefinitely with no timeout.
- start during FILL/WRITE/DONE ignored. Bounds check ensures address never exceeds DEPTH-1; no wrap.
- Checksum width 16, wraps modulo 2^16.

Test Plan:
- base=0x0010, count=8, bytes 0x11,0x22..0x88 back-to-back -> write addr 0x0010 data 0x44332211 be 0xF, write addr 0x0011 data 0x88776655 be 0xF; done 1 cycle after second write; checksum 0x0264.
- base=0x0000, count=5, bytes 0xAA,0xBB,0xCC,0xDD,0xEE -> writes 0xDDCCBBAA be 0xF at 0, then 0x000000EE be 0x1 at 1; checksum 0x03FC.
- count=0 -> done 1 cycle after start, busy never 1, no mem_write.
- base=51199, count=8 -> error pulse 1 cycle after start, no writes, busy 0; base=51198, count=8 -> writes at 51198 and 51199, done, no error.
- count=8 with s_valid toggling 1/0 every cycle -> s_ready low in each WRITE cycle, no byte lost or duplicated, same data as test 1.
- reset_n low after 2 bytes accepted -> all outputs 0 immediately, no write; after release, fresh start count=4 -> single clean write, checksum of the new 4 bytes only.

Source files
------------

// File: rtl/nios2_mem_stream_loader.sv
// Byte-stream loader for the on-chip program/data RAM: packs an 8-bit stream
// little-endian into 32-bit words and writes them to sequential word addresses.
module nios2_mem_stream_loader #(
  parameter int DEPTH  = 51200,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum
);

  localparam int SUM_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        lane;
  logic [31:0]       pack_data;
  logic [3:0]        pack_be;
  logic [31:0]       next_data;
  logic [3:0]        next_be;
  logic [SUM_W-1:0]  words_needed;
  logic [SUM_W-1:0]  end_word;
  logic              out_of_range;

  // Word count is rounded up without adding 3 first, so a full-scale count cannot overflow.
  assign words_needed = SUM_W'(byte_count >> 2) + SUM_W'(byte_count[1:0] != 2'b00);
  assign end_word     = SUM_W'(base_addr) + words_needed;
  assign out_of_range = end_word > SUM_W'(DEPTH);

  assign s_ready        = (state == FILL);
  assign busy           = (state == FILL) || (state == WRITE);
  assign mem_write      = (state == WRITE);
  assign mem_chipselect = (state == WRITE);

  always_comb begin
    next_data = pack_data;
    next_data[lane*8 +: 8] = s_data;
    next_be = pack_be | (4'b0001 << lane);
  end

  // The mem_* data/address registers load only when entering WRITE, so they hold between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      lane           <= '0;
      pack_data      <= '0;
      pack_be        <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      mem_clken      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      checksum       <= '0;
    end else begin
      mem_clken <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (byte_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (out_of_range) begin
              error <= 1'b1;
            end else begin
              state     <= FILL;
              addr      <= base_addr;
              remaining <= byte_count;
              lane      <= '0;
              pack_data <= '0;
              pack_be   <= '0;
              checksum  <= '0;
            end
          end
        end
        FILL: begin
          if (s_valid) begin
            pack_data <= next_data;
            pack_be   <= next_be;
            checksum  <= checksum + {8'h00, s_data};
            remaining <= remaining - CNT_W'(1);
            if ((lane == 2'd3) || (remaining == CNT_W'(1))) begin
              state          <= WRITE;
              mem_address    <= addr;
              mem_writedata  <= next_data;
              mem_byteenable <= next_be;
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end
        WRITE: begin
          if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= FILL;
            addr      <= addr + ADDR_W'(1);
            lane      <= '0;
            pack_data <= '0;
            pack_be   <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mem_stream_loader.sv
// Randomized directed bench for nios2_mem_stream_loader; expected writes and
// checksums are derived from the byte list by plain packing arithmetic.
module tb_nios2_mem_stream_loader;

  localparam int DEPTH  = 51200;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 18;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  byte_count;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       checksum;

  nios2_mem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
    .done(done), .error(error), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stim[$];
  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_be[$];
  int          write_cyc[$];
  int          done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, start_cyc;
  int          overlap_cnt = 0;

  // Passive monitor: samples mid-cycle and records every RAM write and pulse.
  always @(negedge clk) begin
    if (mem_write && mem_chipselect) begin
      got_addr.push_back(mem_address);
      got_data.push_back(mem_writedata);
      got_be.push_back(mem_byteenable);
      write_cyc.push_back(cyc);
    end
    if (mem_write && s_ready) overlap_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (busy) busy_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_monitor();
    got_addr.delete(); got_data.delete(); got_be.delete(); write_cyc.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic random_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // mode 0: continuous valid, 1: toggle every cycle, 2: random gaps
  task automatic feed_bytes(input int n, input int mode);
    int idx = 0;
    int iter = 0;
    while (idx < n && iter < 2000) begin
      @(negedge clk);
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (iter % 2 == 0);
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = stim[idx];
      #1;
      if (s_valid && s_ready) idx++;
      iter++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (idx != n) check_output("feed_timeout", 32'(idx), 32'(n));
  endtask

  task automatic apply_stimulus(input logic [15:0] base, input int count,
                                input int mode, input bit expect_err);
    int budget = 60;
    clear_monitor();
    @(negedge clk);
    start = 1'b1; base_addr = base; byte_count = CNT_W'(count); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (!expect_err && count > 0) feed_bytes(count, mode);
    while (done_cnt == 0 && err_cnt == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) check_output("completion_timeout", 32'(0), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  // Reference: word w holds bytes 4w..4w+3 little-endian, enables only for present bytes.
  task automatic check_load(input string tag, input logic [15:0] base, input int count);
    int          n_words = (count + 3) / 4;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    int          sum = 0;
    check_output({tag, "_nwrites"}, 32'(got_addr.size()), 32'(n_words));
    for (int w = 0; w < n_words && w < got_addr.size(); w++) begin
      exp_data = '0;
      exp_be   = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < count) begin
          exp_data = exp_data | (32'(stim[4 * w + k]) << (8 * k));
          exp_be[k] = 1'b1;
        end
      end
      check_output({tag, "_addr"}, 32'(got_addr[w]), 32'(base) + 32'(w));
      check_output({tag, "_data"}, got_data[w], exp_data);
      check_output({tag, "_be"}, 32'(got_be[w]), 32'(exp_be));
    end
    for (int i = 0; i < count; i++) sum += int'(stim[i]);
    check_output({tag, "_checksum"}, 32'(checksum), 32'(sum % 65536));
    check_output({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    check_output({tag, "_err_cnt"}, 32'(err_cnt), 32'(0));
    if (write_cyc.size() > 0)
      check_output({tag, "_done_lat"}, 32'(done_cyc), 32'(write_cyc[write_cyc.size() - 1] + 1));
    check_output({tag, "_busy_seen"}, 32'(busy_cnt > 0), 32'(1));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; byte_count = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_clken", 32'(mem_clken), 32'(0));
    check_output("rst_outputs", {26'(0), s_ready, busy, mem_write, mem_chipselect, done, error},
                 32'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_clken", 32'(mem_clken), 32'(1));

    $display("[TB] aligned 8-byte load, continuous stream");
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    apply_stimulus(16'h0010, 8, 0, 1'b0);
    check_load("t1", 16'h0010, 8);
    check_output("t1_checksum_const", 32'(checksum), 32'h0264);
    if (write_cyc.size() == 2)
      check_output("t1_throughput", 32'(write_cyc[1] - write_cyc[0]), 32'(5));

    $display("[TB] partial trailing word");
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    apply_stimulus(16'h0000, 5, 0, 1'b0);
    check_load("t2", 16'h0000, 5);
    check_output("t2_checksum_const", 32'(checksum), 32'h03FC);

    $display("[TB] out-of-range request");
    apply_stimulus(16'(DEPTH - 1), 8, 0, 1'b1);
    check_output("oob_err_cnt", 32'(err_cnt), 32'(1));
    check_output("oob_err_lat", 32'(err_cyc), 32'(start_cyc + 1));
    check_output("oob_nwrites", 32'(got_addr.size()), 32'(0));
    check_output("oob_busy", 32'(busy_cnt), 32'(0));
    check_output("oob_done", 32'(done_cnt), 32'(0));
    check_output("oob_checksum", 32'(checksum), 32'h03FC);

    $display("[TB] zero-length request");
    apply_stimulus(16'h0100, 0, 0, 1'b0);
    check_output("zero_done_cnt", 32'(done_cnt), 32'(1));
    check_output("zero_done_lat", 32'(done_cyc), 32'(start_cyc + 1));
    check_output("zero_busy", 32'(busy_cnt), 32'(0));
    check_output("zero_nwrites", 32'(got_addr.size()), 32'(0));

    $display("[TB] load ending at last RAM word");
    random_stim(8);
    apply_stimulus(16'(DEPTH - 2), 8, 2, 1'b0);
    check_load("top", 16'(DEPTH - 2), 8);

    $display("[TB] toggling valid");
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    apply_stimulus(16'h0010, 8, 1, 1'b0);
    check_load("toggle", 16'h0010, 8);

    $display("[TB] randomized loads");
    for (int t = 0; t < 5; t++) begin
      int cnt = $urandom_range(1, 24);
      logic [15:0] b = 16'($urandom_range(0, DEPTH - 7));
      random_stim(cnt);
      apply_stimulus(b, cnt, 2, 1'b0);
      check_load("rand", b, cnt);
    end

    $display("[TB] reset in the middle of a load");
    clear_monitor();
    random_stim(8);
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0005; byte_count = CNT_W'(8);
    @(negedge clk);
    start = 1'b0;
    feed_bytes(2, 0);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_ctrl", {25'(0), mem_clken, s_ready, busy, mem_write, mem_chipselect,
                 done, error}, 32'(0));
    check_output("mid_rst_addr", 32'(mem_address), 32'(0));
    check_output("mid_rst_data", mem_writedata, 32'(0));
    check_output("mid_rst_be", 32'(mem_byteenable), 32'(0));
    check_output("mid_rst_checksum", 32'(checksum), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("mid_rst_nwrites", 32'(got_addr.size()), 32'(0));
    random_stim(4);
    apply_stimulus(16'h0020, 4, 0, 1'b0);
    check_load("after_rst", 16'h0020, 4);

    check_output("ready_during_write", 32'(overlap_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
